// File: rtl/reg_bank_if.sv
// Register bank access bus: one write port and two registered read ports.
interface reg_bank_if;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg_1;
  logic [4:0]  read_reg_2;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;

  modport master (
    output reg_write, write_reg, write_data, read_reg_1, read_reg_2,
    input  read_data_1, read_data_2
  );

  modport slave (
    input  reg_write, write_reg, write_data, read_reg_1, read_reg_2,
    output read_data_1, read_data_2
  );
endinterface

// File: rtl/reg_bank.sv
// 32x32 register file, r0 hard-wired to zero, r29 resets to SP_RESET,
// registered read ports with optional same-cycle write forwarding.
module reg_bank #(
  parameter logic [31:0] SP_RESET = 32'd227,
  parameter bit          BYPASS   = 1'b1
) (
  input logic        clk,
  input logic        reset,
  reg_bank_if.slave  bus
);

  logic [31:0] r_regs [32];
  logic [31:0] r_rd1;
  logic [31:0] r_rd2;
  logic        w_wen;
  logic [31:0] w_rd1_next;
  logic [31:0] w_rd2_next;

  assign w_wen = bus.reg_write && (bus.write_reg != 5'd0);

  // Index 0 always reads zero, even when a forwarded write targets it.
  always_comb begin
    w_rd1_next = r_regs[bus.read_reg_1];
    if (bus.read_reg_1 == 5'd0)
      w_rd1_next = '0;
    else if (BYPASS && w_wen && (bus.write_reg == bus.read_reg_1))
      w_rd1_next = bus.write_data;
  end

  always_comb begin
    w_rd2_next = r_regs[bus.read_reg_2];
    if (bus.read_reg_2 == 5'd0)
      w_rd2_next = '0;
    else if (BYPASS && w_wen && (bus.write_reg == bus.read_reg_2))
      w_rd2_next = bus.write_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 32; i++)
        r_regs[i] <= (i == 29) ? SP_RESET : '0;
      r_rd1 <= '0;
      r_rd2 <= '0;
    end else begin
      if (w_wen)
        r_regs[bus.write_reg] <= bus.write_data;
      r_rd1 <= w_rd1_next;
      r_rd2 <= w_rd2_next;
    end
  end

  assign bus.read_data_1 = r_rd1;
  assign bus.read_data_2 = r_rd2;

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench driving a forwarding and a non-forwarding reg_bank in lockstep.
module tb_reg_bank;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  reg_bank_if bus_b ();
  reg_bank_if bus_n ();

  reg_bank #(.SP_RESET(32'd227), .BYPASS(1'b1)) u_byp (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  reg_bank #(.SP_RESET(32'd227), .BYPASS(1'b0)) u_nob (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_n.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    bus_b.reg_write = we; bus_b.write_reg = wr; bus_b.write_data = wd;
    bus_b.read_reg_1 = r1; bus_b.read_reg_2 = r2;
    bus_n.reg_write = we; bus_n.write_reg = wr; bus_n.write_data = wd;
    bus_n.read_reg_1 = r1; bus_n.read_reg_2 = r2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    #1 reset = 1'b0;
    #2;
    chk("rst_b_rd1", bus_b.read_data_1, 32'd0);
    chk("rst_b_rd2", bus_b.read_data_2, 32'd0);
    chk("rst_n_rd1", bus_n.read_data_1, 32'd0);
    step();
    step();
    #2 reset = 1'b1;

    // Reset values of r29 and r5
    drive(1'b0, 5'd0, 32'd0, 5'd29, 5'd5);
    step();
    chk("sp_b", bus_b.read_data_1, 32'd227);
    chk("r5_b", bus_b.read_data_2, 32'd0);
    chk("sp_n", bus_n.read_data_1, 32'd227);

    // Write then read r8; r24 must not alias
    drive(1'b1, 5'd8, 32'hDEADBEEF, 5'd1, 5'd2);
    step();
    drive(1'b0, 5'd0, 32'd0, 5'd8, 5'd24);
    step();
    chk("r8_b", bus_b.read_data_1, 32'hDEADBEEF);
    chk("r8_n", bus_n.read_data_1, 32'hDEADBEEF);
    chk("r24_alias", bus_b.read_data_2, 32'd0);

    // Writes to r0 discarded, including forwarded reads
    drive(1'b1, 5'd0, 32'h1234, 5'd8, 5'd0);
    step();
    chk("r0_same_b", bus_b.read_data_2, 32'd0);
    chk("r0_same_n", bus_n.read_data_2, 32'd0);
    drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    step();
    chk("r0_next_b", bus_b.read_data_2, 32'd0);
    chk("r0_next_p1", bus_b.read_data_1, 32'd0);

    // Forwarding vs. no forwarding on r3
    drive(1'b1, 5'd3, 32'h11, 5'd0, 5'd0);
    step();
    drive(1'b1, 5'd3, 32'h22, 5'd3, 5'd3);
    step();
    chk("byp_b_rd1", bus_b.read_data_1, 32'h22);
    chk("byp_b_rd2", bus_b.read_data_2, 32'h22);
    chk("byp_n_rd1", bus_n.read_data_1, 32'h11);
    chk("byp_n_rd2", bus_n.read_data_2, 32'h11);
    drive(1'b0, 5'd3, 32'h33, 5'd3, 5'd0);
    step();
    chk("after_b", bus_b.read_data_1, 32'h22);
    chk("after_n", bus_n.read_data_1, 32'h22);

    // Both ports on r31
    drive(1'b1, 5'd31, 32'hA5A5A5A5, 5'd0, 5'd0);
    step();
    drive(1'b0, 5'd0, 32'd0, 5'd31, 5'd31);
    step();
    chk("r31_p1", bus_b.read_data_1, 32'hA5A5A5A5);
    chk("r31_p2", bus_b.read_data_2, 32'hA5A5A5A5);
    chk("r31_n_p2", bus_n.read_data_2, 32'hA5A5A5A5);

    // Index change between edges must not disturb outputs
    drive(1'b0, 5'd0, 32'd0, 5'd8, 5'd3);
    #3;
    chk("hold_p1", bus_b.read_data_1, 32'hA5A5A5A5);
    chk("hold_p2", bus_b.read_data_2, 32'hA5A5A5A5);

    // Overwrite SP, then reset mid-cycle
    drive(1'b1, 5'd29, 32'h77, 5'd0, 5'd0);
    step();
    drive(1'b0, 5'd0, 32'd0, 5'd29, 5'd31);
    step();
    chk("sp77", bus_b.read_data_1, 32'h77);
    #2 reset = 1'b0;
    #1;
    chk("arst_p1", bus_b.read_data_1, 32'd0);
    chk("arst_p2", bus_b.read_data_2, 32'd0);
    chk("arst_n_p1", bus_n.read_data_1, 32'd0);
    drive(1'b1, 5'd8, 32'h55, 5'd8, 5'd29);
    step();
    chk("rst_edge_p1", bus_b.read_data_1, 32'd0);
    #2 reset = 1'b1;

    // First edge after release both writes and reads
    drive(1'b1, 5'd9, 32'h99, 5'd29, 5'd8);
    step();
    chk("rel_sp", bus_b.read_data_1, 32'd227);
    chk("rel_r8_lost", bus_b.read_data_2, 32'd0);
    chk("rel_n_sp", bus_n.read_data_1, 32'd227);
    drive(1'b0, 5'd0, 32'd0, 5'd9, 5'd31);
    step();
    chk("rel_r9", bus_b.read_data_1, 32'h99);
    chk("rel_r31", bus_b.read_data_2, 32'd0);
    drive(1'b0, 5'd0, 32'd0, 5'd3, 5'd29);
    step();
    chk("rel_r3_n", bus_n.read_data_1, 32'd0);
    chk("rel_sp_n", bus_n.read_data_2, 32'd227);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
